// File: rtl/cs_quant_ctrl.sv
// Adaptive bit_shift sequencer: scans a packet for its peak, fits it into TARGET_BITS and quantizes; accept-to-out_valid REG_BANK_DEPTH+2 cycles.
// One packet in flight; output held until out_ready. Optional CS_QUANT_SHIFT_OVERRIDE_EN adds a cfg_shift bypass of the scan.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef REG_BANK_DEPTH
`define REG_BANK_DEPTH 4
`endif
`ifndef BIT_SHIFT_WIDTH
`define BIT_SHIFT_WIDTH 4
`endif
`ifndef PACKET_LEN
`define PACKET_LEN (`DATA_WIDTH*`REG_BANK_DEPTH)
`endif

module cs_quantization #(
  parameter int DW    = `DATA_WIDTH,
  parameter int DEPTH = `REG_BANK_DEPTH,
  parameter int SW    = `BIT_SHIFT_WIDTH
) (
  input  logic [DW*DEPTH-1:0] y_p,
  input  logic [SW-1:0]       bit_shift,
  output logic [DW*DEPTH-1:0] bit_stream
);
  always_comb begin
    bit_stream = '0;
    for (int i = 0; i < DEPTH; i++) bit_stream[i*DW +: DW] = y_p[i*DW +: DW] >> bit_shift;
  end
endmodule

module cs_quant_ctrl #(
  parameter int TARGET_BITS = 8,
  parameter int MAX_SHIFT   = 2**`BIT_SHIFT_WIDTH-1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`PACKET_LEN-1:0]      in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`PACKET_LEN-1:0]      out_data,
  output logic [`BIT_SHIFT_WIDTH-1:0] out_shift,
  output logic                        out_last,
  output logic [CNT_WIDTH-1:0]        pkt_count,
  output logic                        shift_sat,
`ifdef CS_QUANT_SHIFT_OVERRIDE_EN
  input  logic                        cfg_override,
  input  logic [`BIT_SHIFT_WIDTH-1:0] cfg_shift,
`endif
  input  logic                        sat_clear
);
  localparam int DW    = `DATA_WIDTH;
  localparam int DEPTH = `REG_BANK_DEPTH;
  localparam int SW    = `BIT_SHIFT_WIDTH;
  localparam int PL    = `PACKET_LEN;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_CALC, S_QUANT, S_OUT} state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic [PL-1:0]        r_pkt;
  logic                 r_last;
  logic [IDXW-1:0]      r_idx;
  logic [DW-1:0]        r_max;
  logic [SW-1:0]        r_shift;
  logic                 r_out_valid;
  logic [PL-1:0]        r_out_data;
  logic [SW-1:0]        r_out_shift;
  logic                 r_out_last;
  logic [CNT_WIDTH-1:0] r_pkt_count;
  logic                 r_shift_sat;

  logic [DW-1:0]        w_elem;
  logic [PL-1:0]        w_bit_stream;
  int                   w_len;
  int                   w_need;
  logic                 w_calc_sat;
  logic [SW-1:0]        w_calc_shift;

  assign w_elem = r_pkt[r_idx*DW +: DW];

  // w_len is the bit length of the peak (0 for an all-zero packet).
  always_comb begin
    w_len = 0;
    for (int b = 0; b < DW; b++) if (r_max[b]) w_len = b + 1;
    w_need       = (w_len > TARGET_BITS) ? w_len - TARGET_BITS : 0;
    w_calc_sat   = (w_need > MAX_SHIFT);
    w_calc_shift = w_calc_sat ? SW'(MAX_SHIFT) : SW'(w_need);
  end

  cs_quantization #(.DW(DW), .DEPTH(DEPTH), .SW(SW)) u_quant (
    .y_p        (r_pkt),
    .bit_shift  (r_shift),
    .bit_stream (w_bit_stream)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_pkt       <= '0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_max       <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_shift <= '0;
      r_out_last  <= 1'b0;
      r_pkt_count <= '0;
      r_shift_sat <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_pkt      <= in_data;
            r_last     <= in_last;
            r_idx      <= '0;
            r_max      <= '0;
`ifdef CS_QUANT_SHIFT_OVERRIDE_EN
            if (cfg_override) begin
              r_shift <= cfg_shift;
              r_state <= S_QUANT;
            end else begin
              r_state <= S_SCAN;
            end
`else
            r_state <= S_SCAN;
`endif
          end
        end
        S_SCAN: begin
          if (w_elem > r_max) r_max <= w_elem;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDXW'(DEPTH-1)) r_state <= S_CALC;
        end
        S_CALC: begin
          r_shift <= w_calc_shift;
          if (w_calc_sat) r_shift_sat <= 1'b1;
          r_state <= S_QUANT;
        end
        S_QUANT: begin
          r_out_data  <= w_bit_stream;
          r_out_shift <= r_shift;
          r_out_last  <= r_last;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pkt_count <= r_pkt_count + 1'b1;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Clear takes priority over a set in the same cycle.
      if (sat_clear) r_shift_sat <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_shift = r_out_shift;
  assign out_last  = r_out_last;
  assign pkt_count = r_pkt_count;
  assign shift_sat = r_shift_sat;
endmodule

// File: tb/tb_cs_quant_ctrl.sv
// Randomized bench for cs_quant_ctrl: a default instance and a saturating one (TARGET_BITS=1, MAX_SHIFT=12) share stimulus.
module tb_cs_quant_ctrl;
  localparam int DW = 16, N = 4, SW = 4, PL = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, sat_clear = 1'b0;
  logic [PL-1:0] in_data = '0;

  logic a_in_ready, a_out_valid, a_out_last, a_shift_sat;
  logic [PL-1:0] a_out_data;
  logic [SW-1:0] a_out_shift;
  logic [15:0]   a_pkt_count;
  logic b_in_ready, b_out_valid, b_out_last, b_shift_sat;
  logic [PL-1:0] b_out_data;
  logic [SW-1:0] b_out_shift;
  logic [15:0]   b_pkt_count;

  cs_quant_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_shift(a_out_shift), .out_last(a_out_last), .pkt_count(a_pkt_count),
    .shift_sat(a_shift_sat), .sat_clear(sat_clear)
  );

  cs_quant_ctrl #(.TARGET_BITS(1), .MAX_SHIFT(12)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_shift(b_out_shift), .out_last(b_out_last), .pkt_count(b_pkt_count),
    .shift_sat(b_shift_sat), .sat_clear(sat_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_count = 0;
  bit m_sat_a = 1'b0, m_sat_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Shift needed to fit the packet peak into tb significant bits.
  function automatic int need_of(input logic [PL-1:0] p, input int tb);
    int unsigned mx, len;
    mx = 0;
    for (int i = 0; i < N; i++) if (32'(p[i*DW +: DW]) > mx) mx = 32'(p[i*DW +: DW]);
    len = $clog2(mx + 1);
    return (len > tb) ? int'(len) - tb : 0;
  endfunction

  function automatic logic [PL-1:0] quant(input logic [PL-1:0] p, input int sh);
    logic [PL-1:0] q;
    for (int i = 0; i < N; i++) q[i*DW +: DW] = 16'(32'(p[i*DW +: DW]) / (32'h1 << sh));
    return q;
  endfunction

  function automatic logic [PL-1:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                          input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic send(input logic [PL-1:0] p, input bit last, input int hold, input bit clr);
    int na, nb, sa, sb, lat, w;
    logic [PL-1:0] ea, eb;
    na = need_of(p, 8);
    nb = need_of(p, 1);
    sa = (na > 15) ? 15 : na;
    sb = (nb > 12) ? 12 : nb;
    ea = quant(p, sa);
    eb = quant(p, sb);
    w = 0;
    while (!a_in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_idle", 64'(a_in_ready), 64'd1);
    in_data = p; in_last = last; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", 64'(a_in_ready), 64'd0);
    lat = 0;
    while (!a_out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
      sat_clear = clr && (lat == 4);
    end
    sat_clear = 1'b0;
    if (clr) begin m_sat_a = 1'b0; m_sat_b = 1'b0; end
    else begin m_sat_a |= (na > 15); m_sat_b |= (nb > 12); end
    chk("latency", 64'(lat), 64'd6);
    chk("b_valid", 64'(b_out_valid), 64'd1);
    chk("a_data", a_out_data, ea);
    chk("a_shift", 64'(a_out_shift), 64'(sa));
    chk("a_last", 64'(a_out_last), 64'(last));
    chk("a_sat", 64'(a_shift_sat), 64'(m_sat_a));
    chk("b_data", b_out_data, eb);
    chk("b_shift", 64'(b_out_shift), 64'(sb));
    chk("b_sat", 64'(b_shift_sat), 64'(m_sat_b));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_valid", 64'(a_out_valid), 64'd1);
      chk("hold_data", a_out_data, ea);
      chk("hold_meta", {a_out_shift, a_out_last, a_in_ready}, {4'(sa), last, 1'b0});
      chk("hold_count", 64'(a_pkt_count), 64'(m_count));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    m_count = (m_count + 1) % 65536;
    chk("post_valid", 64'(a_out_valid), 64'd0);
    chk("post_ready", 64'(a_in_ready), 64'd1);
    chk("pkt_count", 64'(a_pkt_count), 64'(m_count));
    chk("b_pkt_count", 64'(b_pkt_count), 64'(m_count));
  endtask

  initial begin
    logic [PL-1:0] p;
    bit seen;
    int scale;
    logic [31:0] mask;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_outs", {a_out_valid, a_out_last, a_shift_sat, b_shift_sat, a_out_shift}, 64'd0);
    chk("rst_data", a_out_data, 64'd0);
    chk("rst_count", 64'(a_pkt_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(a_in_ready), 64'd1);

    send(pack4(16'h00FF, 16'h0010, 16'h0000, 16'h0080), 1'b0, 0, 1'b0);
    send(pack4(16'h0400, 16'h0100, 16'h0003, 16'h0000), 1'b1, 0, 1'b0);
    send(64'd0, 1'b0, 0, 1'b0);
    send(pack4(16'h1234, 16'h00F0, 16'h8001, 16'h0002), 1'b1, 10, 1'b0);
    send(pack4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000), 1'b0, 0, 1'b0);
    send(pack4(16'hFFFF, 16'h0001, 16'h0000, 16'h0000), 1'b0, 0, 1'b1);
    send(pack4(16'h0000, 16'h0000, 16'h3000, 16'h0000), 1'b1, 1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      scale = $urandom_range(0, 16);
      mask = (32'h1 << scale) - 1;
      for (int i = 0; i < N; i++) p[i*DW +: DW] = 16'($urandom & mask);
      send(p, 1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    // Reset while the scan is at element 2.
    in_data = pack4(16'hFFFF, 16'h0400, 16'h0001, 16'h0000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {a_out_valid, a_in_ready, a_shift_sat, b_shift_sat, b_out_valid}, 64'd0);
    chk("midrst_data", a_out_data | b_out_data, 64'd0);
    chk("midrst_count", 64'(a_pkt_count) | 64'(b_pkt_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(a_in_ready), 64'd1);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= a_out_valid | b_out_valid; end
    chk("midrst_no_out", 64'(seen), 64'd0);
    send(pack4(16'h0400, 16'h0000, 16'h0000, 16'h0000), 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
